// File: rtl/reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reorder_buffer                                                |
// | Purpose  : Circular in-order ROB: tag allocation, CDB completion,        |
// |            in-order retire with squash on mispredicted branches.         |
// | Options  : ROB_VALUE_FWD_EN adds two combinational value-forward ports.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reorder_buffer #(
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = $clog2(ROB_SIZE) + 1,
  parameter int REG_SIZE = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dispatch_enable,
  input  logic [$clog2(REG_SIZE)-1:0] dispatch_rd,
  input  logic                        dispatch_has_dest,
  output logic [TAG_W-1:0]            dispatch_tag,
  output logic                        rob_full,
  output logic                        rob_empty,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            CDB_tag,
  input  logic [31:0]                 cdb_value,
  input  logic                        cdb_mispredict,
`ifdef ROB_VALUE_FWD_EN
  input  logic [TAG_W-1:0]            rs1_query_tag,
  input  logic [TAG_W-1:0]            rs2_query_tag,
  output logic [31:0]                 rs1_fwd_value,
  output logic [31:0]                 rs2_fwd_value,
  output logic                        rs1_fwd_ready,
  output logic                        rs2_fwd_ready,
`endif
  output logic                        retire_valid,
  output logic [$clog2(REG_SIZE)-1:0] retire_rd,
  output logic [TAG_W-1:0]            retire_tag,
  output logic [31:0]                 retire_value,
  output logic                        clear,
  output logic                        squash
);

  localparam int PTR_W = $clog2(ROB_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int RD_W  = $clog2(REG_SIZE);

  logic [PTR_W-1:0]    head_ptr;
  logic [PTR_W-1:0]    tail_ptr;
  logic [CNT_W-1:0]    count;
  logic [ROB_SIZE-1:0] entry_valid;
  logic [ROB_SIZE-1:0] entry_complete;
  logic [ROB_SIZE-1:0] entry_mispredict;
  logic [ROB_SIZE-1:0] entry_has_dest;
  logic [RD_W-1:0]     entry_rd    [ROB_SIZE];
  logic [31:0]         entry_value [ROB_SIZE];

  logic                cdb_in_range;
  logic [PTR_W-1:0]    cdb_idx;
  logic                do_complete;
  logic                do_dispatch;

  assign rob_full     = (count == CNT_W'(ROB_SIZE));
  assign rob_empty    = (count == '0);
  assign dispatch_tag = TAG_W'(tail_ptr) + TAG_W'(1);

  assign retire_valid = entry_valid[head_ptr] & entry_complete[head_ptr];
  assign retire_rd    = entry_rd[head_ptr];
  assign retire_tag   = TAG_W'(head_ptr) + TAG_W'(1);
  assign retire_value = entry_value[head_ptr];
  assign clear        = retire_valid & entry_has_dest[head_ptr];
  assign squash       = retire_valid & entry_mispredict[head_ptr];

  // Tag 0 means "no producer"; tags above ROB_SIZE name no entry at all.
  assign cdb_in_range = (CDB_tag != '0) && (CDB_tag <= TAG_W'(ROB_SIZE));
  assign cdb_idx      = PTR_W'(CDB_tag - TAG_W'(1));
  assign do_complete  = cdb_valid & cdb_in_range & entry_valid[cdb_idx] & ~squash;
  assign do_dispatch  = dispatch_enable & ~rob_full & ~squash;

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_valid      <= '0;
      entry_complete   <= '0;
      entry_mispredict <= '0;
      entry_has_dest   <= '0;
      head_ptr         <= '0;
      tail_ptr         <= '0;
      count            <= '0;
    end else if (squash) begin
      entry_valid      <= '0;
      entry_complete   <= '0;
      entry_mispredict <= '0;
      head_ptr         <= '0;
      tail_ptr         <= '0;
      count            <= '0;
    end else begin
      // Retire head and dispatch tail never alias: that needs empty or full.
      if (retire_valid) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= head_ptr + PTR_W'(1);
      end
      if (do_complete) begin
        entry_complete[cdb_idx]   <= 1'b1;
        entry_mispredict[cdb_idx] <= cdb_mispredict;
      end
      if (do_dispatch) begin
        entry_valid[tail_ptr]      <= 1'b1;
        entry_complete[tail_ptr]   <= 1'b0;
        entry_mispredict[tail_ptr] <= 1'b0;
        entry_has_dest[tail_ptr]   <= dispatch_has_dest;
        tail_ptr                   <= tail_ptr + PTR_W'(1);
      end
      case ({do_dispatch, retire_valid})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (do_dispatch) entry_rd[tail_ptr]   <= dispatch_rd;
      if (do_complete) entry_value[cdb_idx] <= cdb_value;
    end
  end

`ifdef ROB_VALUE_FWD_EN
  logic [PTR_W-1:0] rs1_idx;
  logic [PTR_W-1:0] rs2_idx;

  assign rs1_idx       = PTR_W'(rs1_query_tag - TAG_W'(1));
  assign rs2_idx       = PTR_W'(rs2_query_tag - TAG_W'(1));
  assign rs1_fwd_ready = (rs1_query_tag != '0) && (rs1_query_tag <= TAG_W'(ROB_SIZE)) &&
                         entry_valid[rs1_idx] && entry_complete[rs1_idx];
  assign rs2_fwd_ready = (rs2_query_tag != '0) && (rs2_query_tag <= TAG_W'(ROB_SIZE)) &&
                         entry_valid[rs2_idx] && entry_complete[rs2_idx];
  assign rs1_fwd_value = rs1_fwd_ready ? entry_value[rs1_idx] : 32'h0;
  assign rs2_fwd_value = rs2_fwd_ready ? entry_value[rs2_idx] : 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// Testbench for reorder_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer;
  localparam int ROB_SIZE = 8;
  localparam int TW       = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          dispatch_enable;
  logic [4:0]    dispatch_rd;
  logic          dispatch_has_dest;
  logic [TW-1:0] dispatch_tag;
  logic          rob_full;
  logic          rob_empty;
  logic          cdb_valid;
  logic [TW-1:0] CDB_tag;
  logic [31:0]   cdb_value;
  logic          cdb_mispredict;
  logic          retire_valid;
  logic [4:0]    retire_rd;
  logic [TW-1:0] retire_tag;
  logic [31:0]   retire_value;
  logic          clear;
  logic          squash;
`ifdef ROB_VALUE_FWD_EN
  logic [TW-1:0] rs1_query_tag = '0;
  logic [TW-1:0] rs2_query_tag = '0;
  logic [31:0]   rs1_fwd_value;
  logic [31:0]   rs2_fwd_value;
  logic          rs1_fwd_ready;
  logic          rs2_fwd_ready;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock(clock), .reset(reset),
    .dispatch_enable(dispatch_enable), .dispatch_rd(dispatch_rd),
    .dispatch_has_dest(dispatch_has_dest), .dispatch_tag(dispatch_tag),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .cdb_valid(cdb_valid), .CDB_tag(CDB_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict),
`ifdef ROB_VALUE_FWD_EN
    .rs1_query_tag(rs1_query_tag), .rs2_query_tag(rs2_query_tag),
    .rs1_fwd_value(rs1_fwd_value), .rs2_fwd_value(rs2_fwd_value),
    .rs1_fwd_ready(rs1_fwd_ready), .rs2_fwd_ready(rs2_fwd_ready),
`endif
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_tag(retire_tag),
    .retire_value(retire_value), .clear(clear), .squash(squash)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order list of in-flight instructions.
  typedef struct {
    int          tag;
    int          rd;
    bit          hd;
    bit          done;
    bit          mis;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  int   next_tag = 1;
  bit   model_on = 0;

  always @(posedge clock) begin
    bit   rv, sq, full;
    ent_t e;
    if (reset) begin
      q.delete();
      next_tag = 1;
      model_on = 1;
    end else begin
      rv   = (q.size() > 0) && q[0].done;
      sq   = rv && q[0].mis;
      full = (q.size() == ROB_SIZE);
      if (sq) begin
        q.delete();
        next_tag = 1;
      end else begin
        if (cdb_valid) begin
          foreach (q[i]) begin
            if (q[i].tag == int'(CDB_tag)) begin
              e = q[i];
              e.done = 1;
              e.val  = cdb_value;
              e.mis  = cdb_mispredict;
              q[i]   = e;
            end
          end
        end
        if (rv) void'(q.pop_front());
        if (dispatch_enable && !full) begin
          e.tag  = next_tag;
          e.rd   = int'(dispatch_rd);
          e.hd   = dispatch_has_dest;
          e.done = 0;
          e.mis  = 0;
          e.val  = '0;
          q.push_back(e);
          next_tag = next_tag % ROB_SIZE + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    bit rv;
    if (model_on) begin
      rv = (q.size() > 0) && q[0].done;
      check("m_empty", 32'(rob_empty), 32'(q.size() == 0));
      check("m_full", 32'(rob_full), 32'(q.size() == ROB_SIZE));
      if (q.size() < ROB_SIZE) check("m_dispatch_tag", 32'(dispatch_tag), 32'(next_tag));
      check("m_retire_valid", 32'(retire_valid), 32'(rv));
      if (rv) begin
        check("m_retire_tag", 32'(retire_tag), 32'(q[0].tag));
        check("m_retire_rd", 32'(retire_rd), 32'(q[0].rd));
        check("m_retire_value", retire_value, q[0].val);
        check("m_clear", 32'(clear), 32'(q[0].hd));
        check("m_squash", 32'(squash), 32'(q[0].mis));
      end else begin
        check("m_clear_idle", 32'(clear), 32'd0);
        check("m_squash_idle", 32'(squash), 32'd0);
      end
    end
  end

  task automatic cyc(input bit en, input int rd, input bit cv, input int ctag,
                     input logic [31:0] cval, input bit cmis);
    dispatch_enable   = en;
    dispatch_rd       = 5'(rd);
    dispatch_has_dest = (rd != 0);
    cdb_valid         = cv;
    CDB_tag           = TW'(ctag);
    cdb_value         = cval;
    cdb_mispredict    = cmis;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic disp(input int rd);
    cyc(1, rd, 0, 0, 32'h0, 0);
  endtask

  task automatic cdb(input int tag, input logic [31:0] val, input bit mis);
    cyc(0, 0, 1, tag, val, mis);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    dispatch_enable = 0; dispatch_rd = 0; dispatch_has_dest = 0;
    cdb_valid = 0; CDB_tag = 0; cdb_value = 0; cdb_mispredict = 0;
    repeat (2) @(negedge clock);
    check("rst_empty", 32'(rob_empty), 32'd1);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_tag", 32'(dispatch_tag), 32'd1);
    check("rst_rv", 32'(retire_valid), 32'd0);
    check("rst_clear", 32'(clear), 32'd0);
    check("rst_squash", 32'(squash), 32'd0);
    reset = 1'b0;

    // Basic dispatch, completion, retire
    disp(15);
    check("t1_tag2", 32'(dispatch_tag), 32'd2);
    check("t1_nonempty", 32'(rob_empty), 32'd0);
    disp(11);
    check("t1_tag3", 32'(dispatch_tag), 32'd3);
    check("t1_no_rv", 32'(retire_valid), 32'd0);
    cdb(1, 32'hAA, 0);
    check("t1_rv", 32'(retire_valid), 32'd1);
    check("t1_rd", 32'(retire_rd), 32'd15);
    check("t1_val", retire_value, 32'hAA);
    check("t1_clear", 32'(clear), 32'd1);
    idle();
    check("t1_wait2", 32'(retire_valid), 32'd0);
    cdb(2, 32'hBB, 0);
    check("t1_rv2_tag", 32'(retire_tag), 32'd2);
    check("t1_rv2_rd", 32'(retire_rd), 32'd11);
    idle();
    check("t1_empty", 32'(rob_empty), 32'd1);

    // Out-of-order completion, in-order retire
    do_reset();
    disp(1); disp(2); disp(3);
    cdb(3, 32'h33, 0);
    check("t2_no_rv_a", 32'(retire_valid), 32'd0);
    cdb(2, 32'h22, 0);
    check("t2_no_rv_b", 32'(retire_valid), 32'd0);
    cdb(1, 32'h11, 0);
    check("t2_tag1", 32'(retire_tag), 32'd1);
    idle();
    check("t2_tag2", 32'(retire_tag), 32'd2);
    check("t2_val2", retire_value, 32'h22);
    idle();
    check("t2_tag3", 32'(retire_tag), 32'd3);
    check("t2_val3", retire_value, 32'h33);
    idle();
    check("t2_empty", 32'(rob_empty), 32'd1);

    // Full, dropped dispatch, wrap
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) disp(i + 1);
    check("t3_full", 32'(rob_full), 32'd1);
    disp(20);
    check("t3_still_full", 32'(rob_full), 32'd1);
    cdb(1, 32'h100, 0);
    check("t3_rv_full", 32'(retire_valid), 32'd1);
    disp(20);
    check("t3_drop_full", 32'(rob_full), 32'd0);
    check("t3_wrap_tag", 32'(dispatch_tag), 32'd1);
    disp(21);
    check("t3_refull", 32'(rob_full), 32'd1);
    cdb(12, 32'hEE, 0);
    check("t3_badtag", 32'(retire_valid), 32'd0);
    cdb(0, 32'hEE, 0);
    check("t3_zerotag", 32'(retire_valid), 32'd0);

    // Squash on mispredicted branch
    do_reset();
    disp(5); disp(6); disp(7); disp(0);
    cdb(2, 32'h55, 1);
`ifdef ROB_VALUE_FWD_EN
    rs1_query_tag = 4'd2;
    rs2_query_tag = 4'd3;
    #1;
    check("fwd_rs1_ready", 32'(rs1_fwd_ready), 32'd1);
    check("fwd_rs1_value", rs1_fwd_value, 32'h55);
    check("fwd_rs2_ready", 32'(rs2_fwd_ready), 32'd0);
    check("fwd_rs2_value", rs2_fwd_value, 32'h0);
`endif
    cdb(1, 32'h11, 0);
    check("t4_rv1", 32'(retire_tag), 32'd1);
    check("t4_nosq", 32'(squash), 32'd0);
    idle();
    check("t4_rv2", 32'(retire_tag), 32'd2);
    check("t4_squash", 32'(squash), 32'd1);
    check("t4_clear", 32'(clear), 32'd1);
    check("t4_val", retire_value, 32'h55);
    cyc(1, 9, 1, 3, 32'h77, 0);
    check("t4_empty", 32'(rob_empty), 32'd1);
    check("t4_tag1", 32'(dispatch_tag), 32'd1);
    cdb(3, 32'h77, 0);
    check("t4_ignored", 32'(retire_valid), 32'd0);
    check("t4_empty2", 32'(rob_empty), 32'd1);

    // Streaming dispatch+retire across tag wrap
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1, (i * 3) % 32, i >= 2, (i + 6) % 8 + 1, 32'(i * 7 + 1), 0);
    cdb(3, 32'h300, 0);
    cdb(4, 32'h400, 0);
    repeat (3) idle();
    check("t5_empty", 32'(rob_empty), 32'd1);
    check("t5_tag", 32'(dispatch_tag), 32'd5);

    // Reset overrides concurrent activity
    disp(3); disp(4);
    cdb(5, 32'h9, 0);
    reset = 1'b1;
    cyc(1, 8, 1, 6, 32'h1, 0);
    reset = 1'b0;
    check("t6_empty", 32'(rob_empty), 32'd1);
    check("t6_tag", 32'(dispatch_tag), 32'd1);
    check("t6_rv", 32'(retire_valid), 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order reorder buffer for the P6 core; the tag source and retire source for the map table directly downstream of dispatch. Allocates a ROB tag per dispatched instruction (driven to the map table as the rob tail tag), records CDB completions with result values, and retires in program order. Retirement drives the map table's clear/rd_retire path and a squash on mispredicted branches.

Parameters:
ROB_SIZE, 8, number of entries (power of 2, >=2)
TAG_W, $clog2(ROB_SIZE)+1, tag width; tag 0 = ZERO_TAG (no producer), entry i carries tag i+1
REG_SIZE, 32, architectural registers

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
dispatch_enable  in  1  allocate one entry this cycle
dispatch_rd  in  5  destination register of dispatched instruction
dispatch_has_dest  in  1  instruction writes rd (rd!=0)
dispatch_tag  out  TW  tag the allocation receives (tail index+1), valid whenever rob_full=0
rob_full  out  1  no free entry
rob_empty  out  1  no valid entry
cdb_valid  in  1  completion broadcast
CDB_tag  in  TW  completing tag
cdb_value  in  32  result value
cdb_mispredict  in  1  completing instruction is a mispredicted branch
retire_valid  out  1  head entry retires at next edge
retire_rd  out  5  head destination (to map table rd_retire)
retire_tag  out  TW  head tag
retire_value  out  32  head result
clear  out  1  retire_valid & head has_dest (to map table)
squash  out  1  head retiring with mispredict flag set

Behaviour:
- State: per-entry valid, complete, mispredict, has_dest, rd, value; head ptr, tail ptr (log2 ROB_SIZE bits, wrap modulo ROB_SIZE), count (0..ROB_SIZE).
- Reset (sync): all valid/complete cleared, head=tail=count=0; outputs: retire_valid=0, clear=0, squash=0, rob_empty=1, rob_full=0, dispatch_tag=1.
- Outputs combinational from registered state; rob_full = (count==ROB_SIZE), rob_empty = (count==0).
- Dispatch: dispatch_enable & ~rob_full & ~squash -> at edge write tail entry (valid=1, complete=0, mispredict=0), tail++, count++. Dispatch while full or during squash is dropped silently.
- Full is from pre-edge count: retire and dispatch in same cycle when full -> dispatch still dropped.
- Complete: cdb_valid & CDB_tag!=0 & entry[CDB_tag-1].valid -> set complete, store value, mispredict. CDB to invalid entry or ZERO_TAG ignored. Completion visible for retire next cycle (no same-cycle bypass).
- Retire: retire_valid = head valid & complete; at edge clear head valid, head++, count--. One retire/cycle.
- Simultaneous dispatch+retire (not full): count unchanged, both pointers advance.
- Squash: squash = retire_valid & head.mispredict. Branch itself retires (clear per has_dest); at that edge all entries invalidated, head=tail=count=0. Concurrent dispatch and CDB writes dropped.
- Wrap: tail/head roll from ROB_SIZE-1 to 0; tags roll ROB_SIZE -> 1.
- Reset mid-operation overrides dispatch, complete, retire, squash.

Optional Feature:
ROB_VALUE_FWD_EN: adds inputs rs1_query_tag, rs2_query_tag (TW) and outputs rs1_fwd_value, rs2_fwd_value (32), rs1_fwd_ready, rs2_fwd_ready (1), combinational: ready=1 and value=entry value when query tag!=0, entry valid and complete; else ready=0, value=0. Without macro ports absent, no read muxes.

Test Plan:
- Reset: hold reset 2 cycles -> rob_empty=1, rob_full=0, dispatch_tag=1, retire_valid=clear=squash=0.
- Dispatch rd=15, then rd=11 -> dispatch_tag 1 then 2; retire_valid=0; no retire until CDB_tag=1 (value 0xAA) arrives, then next cycle retire_valid=1, retire_rd=15, retire_value=0xAA, clear=1.
- Out-of-order completion: dispatch tags 1,2,3; CDB 3 then 2 -> no retire; CDB 1 -> tags 1,2,3 retire on three consecutive cycles in order.
- Full/wrap: dispatch 8 with no completes -> rob_full=1, 9th dispatch dropped (count stays 8); complete+retire tag 1 -> next dispatch gets tag 1.
- Squash: dispatch tags 1..4, CDB tag 2 with mispredict=1, CDB tag 1 -> retire 1, then retire 2 with squash=1; next cycle rob_empty=1, dispatch_tag=1; CDB tag 3 afterward ignored.
- ROB_VALUE_FWD_EN: tag 2 completed value 0x55, rs1_query_tag=2 -> rs1_fwd_ready=1, value 0x55; rs2_query_tag=3 (incomplete) -> ready=0.
